mem_arb_2: RTL and testbench
============================

MEM_ARB_2 -- requirements
Module: mem_arb_2

Interface
REQ-001 Parameter: ADDR_W, default 10, word address width toward memory and requesters.
REQ-002 Parameter: DATA_W, default 32, data width; byteenable width = DATA_W/8.
REQ-003 Parameter: RD_LAT, default 1, memory read latency in cycles (legal 1..4).
REQ-004 Ports, in order:
  clk  in  1  single clock, all logic rising-edge;
  reset  in  1  synchronous, active-high;
  mN_address  in  ADDR_W  requester N address (N = 0,1, one set per requester);
  mN_read  in  1  read request;
  mN_write  in  1  write request;
  mN_writedata  in  DATA_W  write data;
  mN_byteenable  in  DATA_W/8  byte lanes;
  mN_waitrequest  out  1  request not accepted this cycle;
  mN_readdata  out  DATA_W  read data;
  mN_readdatavalid  out  1  mN_readdata valid this cycle;
  mem_address  out  ADDR_W;  mem_clken  out  1;  mem_chipselect  out  1;  mem_write  out  1;
  mem_writedata  out  DATA_W;  mem_byteenable  out  DATA_W/8;  mem_readdata  in  DATA_W;
  mem_reset_req  out  1  memory reset request.
REQ-005 Clock and reset are one clock domain with synchronous, active-high reset; no other clock.

Function
REQ-006 reqN = mN_read | mN_write; if both asserted, transaction is a write and read is ignored.
REQ-007 At most one grant per cycle; grant is combinational from reqN and the registered round-robin pointer rr.
REQ-008 Only one reqN high: that requester granted. Both high: requester != rr_last granted (rr_last = last granted index).
REQ-009 rr_last updates on the clock edge after any grant; holds when no grant.
REQ-010 mN_waitrequest = reqN & ~grantN; asserted whenever reset high; deasserted when reqN low.
REQ-011 Granted cycle: mem_chipselect=1, mem_write = granted write, mem_address/writedata/byteenable = granted requester's inputs; no grant: mem_chipselect=0, mem_write=0, other mem_* outputs don't-care.
REQ-012 mem_clken held 1; mem_reset_req = reset.
REQ-013 Each granted read pushes tag {valid=1, id=N} into an RD_LAT-deep shift register; other cycles push {0,x}.
REQ-014 Tag at stage RD_LAT aligns with mem_readdata: mN_readdatavalid = tag.valid & (tag.id==N), exactly RD_LAT cycles after the grant cycle.
REQ-015 mN_readdata = mem_readdata for both ports; only readdatavalid is steered.
REQ-016 Back-to-back reads from either/both requesters sustain one read per cycle; no bubbles, returns in grant order.
REQ-017 Write then read of same address in consecutive cycles: read returns the written data (memory ordering preserved, no reordering in arbiter).
REQ-018 Starvation bound: requester continuously requesting is granted within 2 cycles.
REQ-019 Writes produce no readdatavalid.

Reset
REQ-020 While reset high: no grant, mem_chipselect=0, mem_write=0, both waitrequest=1, mem_reset_req=1.
REQ-021 First clock edge with reset high: rr_last := 1 (requester 0 wins first tie), all tag stages invalid.
REQ-022 Reads in flight at reset are dropped: mN_readdatavalid=0 from the cycle after the reset edge onward until a new post-reset read completes.
REQ-023 First cycle after reset deasserts, requests are accepted normally.

Verification
REQ-024 Reset, then both m0_read(addr 0x010) and m1_read(addr 0x020) held high with RD_LAT=1 -> grants 0,1,0,1...; m0_readdatavalid and m1_readdatavalid alternate starting 1 cycle after first grant with contents of 0x010/0x020.
REQ-025 m0_write 0x3FF data 0xDEADBEEF be 0xF, next cycle m1_read 0x3FF -> m1_readdatavalid with 0xDEADBEEF at RD_LAT cycles after read grant; no m0_readdatavalid.
REQ-026 m0_write 0x005 data 0x11223344 be 0x2 over prior 0x00000000, then m0_read 0x005 -> readdata 0x00003300.
REQ-027 m1 requests alone 8 cycles -> m1_waitrequest=0 all 8 cycles; m0 idle, m0_waitrequest=0.
REQ-028 RD_LAT=3, m0_read granted, reset asserted 1 cycle later for 1 cycle -> no readdatavalid on either port for the aborted read; both waitrequest=1 during reset.
REQ-029 m0_read and m0_write both high, addr 0x001, data 0xA5A5A5A5 -> mem_write=1, no readdatavalid, later read of 0x001 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_arb_2.sv
// mem_arb_2: two-requester round-robin arbiter onto a single-port memory
// with a read-tag pipeline steering readdatavalid back to the issuing port.
module mem_arb_2 #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_clken,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_reset_req
);
  logic req0, req1, g0, g1;
  logic rr_last_q, rr_last_d;
  logic [RD_LAT-1:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    g0 = ~reset & req0 & (~req1 | rr_last_q);
    g1 = ~reset & req1 & ~g0;
    rr_last_d = g0 ? 1'b0 : g1 ? 1'b1 : rr_last_q;
    // stage 0 takes the tag of this cycle's read; stage RD_LAT-1 lines up with mem_readdata
    tag_v_d[0] = (g0 & ~m0_write) | (g1 & ~m1_write);
    tag_id_d[0] = g1;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= 1'b1;
      tag_v_q <= '0;
      tag_id_q <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end
  assign m0_waitrequest = reset | (req0 & ~g0);
  assign m1_waitrequest = reset | (req1 & ~g1);
  assign mem_chipselect = g0 | g1;
  assign mem_write = g0 ? m0_write : (g1 & m1_write);
  assign mem_address = g0 ? m0_address : m1_address;
  assign mem_writedata = g0 ? m0_writedata : m1_writedata;
  assign mem_byteenable = g0 ? m0_byteenable : m1_byteenable;
  assign mem_clken = 1'b1;
  assign mem_reset_req = reset;
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;
  assign m0_readdatavalid = tag_v_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
  assign m1_readdatavalid = tag_v_q[RD_LAT-1] & tag_id_q[RD_LAT-1];
endmodule

// File: tb/tb_mem_arb_2.sv
// tb_mem_arb_2: drives two arbiters (RD_LAT 1 and 3) with shared stimulus and
// checks them every cycle against a grant/return-queue model of the arbiter.
module tb_mem_arb_2;
  logic clk = 0;
  logic rst = 1;
  logic [9:0] m0_address = 0, m1_address = 0;
  logic m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = 0, m1_writedata = 0;
  logic [3:0] m0_byteenable = 0, m1_byteenable = 0;
  logic m0_wr[2], m1_wr[2], m0_rdv[2], m1_rdv[2];
  logic [31:0] m0_rd[2], m1_rd[2], mem_wd[2], mem_rd[2];
  logic [9:0] mem_addr[2];
  logic [3:0] mem_be[2];
  logic mem_cs[2], mem_we[2], mem_ck[2], mem_rr[2];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arb_2 #(.ADDR_W(10), .DATA_W(32), .RD_LAT(k == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(rst),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_wr[k]), .m0_readdata(m0_rd[k]), .m0_readdatavalid(m0_rdv[k]),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_wr[k]), .m1_readdata(m1_rd[k]), .m1_readdatavalid(m1_rdv[k]),
      .mem_address(mem_addr[k]), .mem_clken(mem_ck[k]), .mem_chipselect(mem_cs[k]),
      .mem_write(mem_we[k]), .mem_writedata(mem_wd[k]), .mem_byteenable(mem_be[k]),
      .mem_readdata(mem_rd[k]), .mem_reset_req(mem_rr[k]));
  end
  function automatic logic [31:0] pat(input logic [9:0] a);
    return (a == 10'h005) ? 32'h0 : (32'hC0DE0000 | 32'(a));
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction
  // memory device behind each arbiter: registered read, RD_LAT-1 extra delay stages
  logic [31:0] ram[2][1024];
  bit wm[2][1024];
  logic [31:0] rpipe[2][4];
  function automatic logic [31:0] ram_rd(input int k, input logic [9:0] a);
    return wm[k][a] ? ram[k][a] : pat(a);
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_ck[k] && mem_cs[k] && mem_we[k]) begin
        ram[k][mem_addr[k]] <= merge(ram_rd(k, mem_addr[k]), mem_wd[k], mem_be[k]);
        wm[k][mem_addr[k]] <= 1'b1;
      end
      rpipe[k][0] <= ram_rd(k, mem_addr[k]);
      for (int j = 1; j < 4; j++) rpipe[k][j] <= rpipe[k][j-1];
    end
  end
  assign mem_rd[0] = rpipe[0][0];
  assign mem_rd[1] = rpipe[1][2];
  // model state: last winner, shadow memory, returns scheduled by cycle number
  int checks = 0, errors = 0, cyc = 0;
  int last[2] = '{1, 1};
  logic [31:0] sh[2][1024];
  bit pv[2][8];
  bit pid[2][8];
  logic [31:0] pd[2][8];
  logic obs_wr0[2], obs_wr1[2], obs_rdv0[2], obs_rdv1[2];
  logic [31:0] obs_d0, obs_d1;
  logic [9:0] obs_addr;
  logic obs_cs, obs_we;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  task automatic step();
    int lat, win, s, e;
    logic r0, r1, wr;
    logic [9:0] a;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 1 : 3;
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      win = -1;
      if (!rst) win = (r0 && r1) ? (last[k] == 0 ? 1 : 0) : r0 ? 0 : r1 ? 1 : -1;
      chk($sformatf("m0_waitrequest[%0d]", k), 32'(m0_wr[k]), 32'(rst | (r0 && win != 0)));
      chk($sformatf("m1_waitrequest[%0d]", k), 32'(m1_wr[k]), 32'(rst | (r1 && win != 1)));
      chk($sformatf("mem_chipselect[%0d]", k), 32'(mem_cs[k]), 32'(win >= 0));
      wr = (win == 0) ? m0_write : (win == 1) ? m1_write : 1'b0;
      chk($sformatf("mem_write[%0d]", k), 32'(mem_we[k]), 32'(wr));
      chk($sformatf("mem_clken[%0d]", k), 32'(mem_ck[k]), 32'd1);
      chk($sformatf("mem_reset_req[%0d]", k), 32'(mem_rr[k]), 32'(rst));
      a = (win == 1) ? m1_address : m0_address;
      if (win >= 0) begin
        chk($sformatf("mem_address[%0d]", k), 32'(mem_addr[k]), 32'(a));
        chk($sformatf("mem_writedata[%0d]", k), mem_wd[k], win ? m1_writedata : m0_writedata);
        chk($sformatf("mem_byteenable[%0d]", k), 32'(mem_be[k]), 32'(win ? m1_byteenable : m0_byteenable));
      end
      s = cyc % 8;
      chk($sformatf("m0_readdatavalid[%0d]", k), 32'(m0_rdv[k]), 32'(pv[k][s] && !pid[k][s]));
      chk($sformatf("m1_readdatavalid[%0d]", k), 32'(m1_rdv[k]), 32'(pv[k][s] && pid[k][s]));
      if (pv[k][s]) begin
        chk($sformatf("m0_readdata[%0d]", k), m0_rd[k], pd[k][s]);
        chk($sformatf("m1_readdata[%0d]", k), m1_rd[k], pd[k][s]);
      end
      pv[k][s] = 0;
      obs_wr0[k] = m0_wr[k]; obs_wr1[k] = m1_wr[k];
      obs_rdv0[k] = m0_rdv[k]; obs_rdv1[k] = m1_rdv[k];
      if (rst) begin
        last[k] = 1;
        for (int j = 0; j < 8; j++) pv[k][j] = 0;
      end else if (win >= 0) begin
        last[k] = win;
        if (wr) sh[k][a] = merge(sh[k][a], win ? m1_writedata : m0_writedata, win ? m1_byteenable : m0_byteenable);
        else begin
          e = (cyc + lat) % 8;
          pv[k][e] = 1; pid[k][e] = (win == 1); pd[k][e] = sh[k][a];
        end
      end
    end
    obs_d0 = m0_rd[0]; obs_d1 = m1_rd[0];
    obs_addr = mem_addr[0]; obs_cs = mem_cs[0]; obs_we = mem_we[0];
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask
  task automatic wait_rdv(input bit port, input logic [31:0] exp, input string name);
    for (int n = 0; n < 6; n++) begin
      step();
      if (port ? obs_rdv1[0] : obs_rdv0[0]) begin
        chk(name, port ? obs_d1 : obs_d0, exp);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s timeout got=no_readdatavalid want=%h", name, exp);
  endtask
  initial begin
    int hits;
    for (int k = 0; k < 2; k++) for (int a = 0; a < 1024; a++) sh[k][a] = pat(10'(a));
    steps(2);
    chk("reset_wait_m0", 32'(obs_wr0[0] & obs_wr0[1]), 32'd1);
    chk("reset_cs", 32'(obs_cs), 32'd0);
    rst = 0;
    // both ports read continuously: strict alternation starting with port 0
    m0_read = 1; m0_address = 10'h010; m1_read = 1; m1_address = 10'h020;
    step();
    chk("first_grant_addr", 32'(obs_addr), 32'h010);
    step();
    chk("second_grant_addr", 32'(obs_addr), 32'h020);
    chk("alt_rdv0", 32'(obs_rdv0[0]), 32'd1);
    chk("alt_data0", obs_d0, 32'hC0DE0010);
    step();
    chk("alt_rdv1", 32'(obs_rdv1[0]), 32'd1);
    chk("alt_data1", obs_d1, 32'hC0DE0020);
    steps(5);
    idle(); steps(4);
    // write then immediate read of the same word from the other port
    m0_write = 1; m0_address = 10'h3FF; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    step();
    idle(); m1_read = 1; m1_address = 10'h3FF;
    step();
    idle();
    wait_rdv(1'b1, 32'hDEADBEEF, "wr_then_rd_3ff");
    steps(3);
    // single byte lane write over zero
    m0_write = 1; m0_address = 10'h005; m0_writedata = 32'h11223344; m0_byteenable = 4'h2;
    step();
    idle(); m0_read = 1; m0_address = 10'h005;
    step();
    idle();
    wait_rdv(1'b0, 32'h00003300, "byte_lane_005");
    steps(3);
    // read+write together is a write
    m0_read = 1; m0_write = 1; m0_address = 10'h001; m0_writedata = 32'hA5A5A5A5; m0_byteenable = 4'hF;
    step();
    chk("rw_is_write", 32'(obs_we), 32'd1);
    idle(); steps(4);
    m0_read = 1; m0_address = 10'h001;
    step();
    idle();
    wait_rdv(1'b0, 32'hA5A5A5A5, "rw_readback_001");
    steps(3);
    // m1 alone for 8 cycles with varying addresses
    for (int i = 0; i < 8; i++) begin
      m1_read = 1; m1_address = 10'(i * 37);
      step();
      chk("m1_alone_wait", 32'(obs_wr1[0]), 32'd0);
    end
    idle(); steps(4);
    // mixed traffic with writes and reads interleaved on both ports
    for (int i = 0; i < 16; i++) begin
      m0_read = i[0]; m0_write = i[1]; m0_address = 10'(i % 4); m0_writedata = 32'h1000 + i; m0_byteenable = 4'hF;
      m1_read = ~i[2]; m1_write = i[3] & i[0]; m1_address = 10'(i % 4); m1_writedata = 32'h2000 + i; m1_byteenable = 4'h5;
      step();
    end
    idle(); steps(4);
    // reset one cycle after a read grant aborts the read on the RD_LAT=3 port
    m0_read = 1; m0_address = 10'h010;
    step();
    idle(); rst = 1;
    step();
    chk("rst_wait_both", 32'(obs_wr0[1] & obs_wr1[1]), 32'd1);
    rst = 0;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      hits += int'(obs_rdv0[1]) + int'(obs_rdv1[1]);
    end
    chk("aborted_read_rdv", 32'(hits), 32'd0);
    m1_read = 1; m1_address = 10'h020;
    step();
    idle(); steps(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
